reg_bank: RTL and testbench

- Parametrised register bank; next-generation successor to the single enable-latched data register.
- Holds REGCOUNT registers of DATASIZE bits each.
- Registers can be accessed singly, or as adjacent even/odd pairs for 2*DATASIZE-bit operations.
- Sits in the datapath as the general-purpose register file: for example B/C, D/E, H/L plus spares, with pair increment/decrement for address-pointer use.

---
 rtl/reg_bank.sv | 59 +++++
 tb/tb_reg_bank.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// reg_bank: a register file of REGCOUNT registers, each DATASIZE bits wide. Registers can be read and written singly or as
// even/odd pairs, and a pair can be incremented or decremented in place.
module reg_bank #(
    parameter int DATASIZE = 8,
    parameter int REGCOUNT = 8,
    parameter int ADDRSIZE = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wenb,
    input  logic [ADDRSIZE-1:0]   waddr,
    input  logic [DATASIZE-1:0]   wdata,
    input  logic                  penb,
    input  logic                  pinc,
    input  logic                  pdec,
    input  logic [ADDRSIZE-2:0]   paddr,
    input  logic [2*DATASIZE-1:0] pdata,
    input  logic [ADDRSIZE-1:0]   raddr,
    output logic [DATASIZE-1:0]   rdata,
    input  logic [ADDRSIZE-2:0]   rpaddr,
    output logic [2*DATASIZE-1:0] rpdata,
    output logic                  pzero
);
    localparam logic [2*DATASIZE-1:0] ONE = {{(2*DATASIZE-1){1'b0}}, 1'b1};

    logic [DATASIZE-1:0]   r_regs [REGCOUNT];
    logic                  r_pzero;
    logic [ADDRSIZE-1:0]   w_hi, w_lo;
    logic [2*DATASIZE-1:0] w_cur, w_res;
    logic                  w_inc, w_dec, w_pop;

    assign w_hi  = {paddr, 1'b0};
    assign w_lo  = {paddr, 1'b1};
    assign w_cur = {r_regs[w_hi], r_regs[w_lo]};
    // A pair write masks increment and decrement. Asserting pinc and pdec together does nothing.
    assign w_inc = ~penb & pinc & ~pdec;
    assign w_dec = ~penb & pdec & ~pinc;
    assign w_pop = penb | w_inc | w_dec;
    assign w_res = penb ? pdata : w_inc ? w_cur + ONE : w_cur - ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REGCOUNT; i++) r_regs[i] <= '0;
            r_pzero <= 1'b0;
        end else begin
            if (w_pop) begin
                r_regs[w_hi] <= w_res[2*DATASIZE-1:DATASIZE];
                r_regs[w_lo] <= w_res[DATASIZE-1:0];
            end
            // The single write comes last, so it wins any byte that it shares with the pair operation.
            if (wenb) r_regs[waddr] <= wdata;
            if (w_inc | w_dec) r_pzero <= (w_res == '0);
        end
    end

    assign rdata  = r_regs[raddr];
    assign rpdata = {r_regs[{rpaddr, 1'b0}], r_regs[{rpaddr, 1'b1}]};
    assign pzero  = r_pzero;
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: a directed bench for reg_bank. A behavioural register-file model is checked against the DUT every cycle,
// and literal expectations pin down the model itself.
module tb_reg_bank;
    logic        clk = 0, rst = 0;
    logic        wenb = 0, penb = 0, pinc = 0, pdec = 0;
    logic [2:0]  waddr = 0, raddr = 0;
    logic [1:0]  paddr = 0, rpaddr = 0;
    logic [7:0]  wdata = 0, rdata;
    logic [15:0] pdata = 0, rpdata;
    logic        pzero;

    logic [7:0]  mdl [8];
    logic        mz = 0;
    bit          cmp_en = 0;
    int          checks = 0, failures = 0;

    reg_bank dut (.clk(clk), .rst(rst), .wenb(wenb), .waddr(waddr), .wdata(wdata), .penb(penb), .pinc(pinc),
                  .pdec(pdec), .paddr(paddr), .pdata(pdata), .raddr(raddr), .rdata(rdata), .rpaddr(rpaddr),
                  .rpdata(rpdata), .pzero(pzero));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mclear();
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        mz = 0;
    endtask

    // Apply one clock edge's worth of register-file behaviour to the model.
    task automatic upd();
        logic [15:0] cur, res;
        int hi, lo;
        if (!rst) begin
            mclear();
            return;
        end
        hi  = 2 * int'(paddr);
        lo  = hi + 1;
        cur = {mdl[hi], mdl[lo]};
        if (penb) begin
            mdl[hi] = pdata[15:8];
            mdl[lo] = pdata[7:0];
        end else if (pinc != pdec) begin
            res     = pinc ? cur + 16'd1 : cur - 16'd1;
            mz      = (res == 16'd0);
            mdl[hi] = res[15:8];
            mdl[lo] = res[7:0];
        end
        if (wenb) mdl[waddr] = wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        upd();
        #1;
        {wenb, penb, pinc, pdec} = 4'b0;
    endtask

    task automatic rd(input int a, input logic [7:0] exp);
        raddr = 3'(a);
        #1;
        chk($sformatf("rd%0d", a), {8'h00, rdata}, {8'h00, exp});
    endtask

    task automatic rdp(input int p, input logic [15:0] exp);
        rpaddr = 2'(p);
        #1;
        chk($sformatf("rdp%0d", p), rpdata, exp);
    endtask

    task automatic pop(input int p, input bit e, input bit i, input bit d, input logic [15:0] v);
        paddr = 2'(p);
        penb = e;
        pinc = i;
        pdec = d;
        pdata = v;
        tick();
    endtask

    always @(negedge clk) if (cmp_en) begin
        chk("cmp_rdata", {8'h00, rdata}, {8'h00, mdl[raddr]});
        chk("cmp_rpdata", rpdata, {mdl[2*int'(rpaddr)], mdl[2*int'(rpaddr)+1]});
        chk("cmp_pzero", {15'h0, pzero}, {15'h0, mz});
    end

    initial begin
        mclear();
        repeat (2) tick();
        rst = 1;
        tick();
        cmp_en = 1;
        for (int i = 0; i < 8; i++) begin
            wenb = 1; waddr = 3'(i); wdata = 8'hA5;
            tick();
        end
        rd(3, 8'hA5);
        // The reset falls between clock edges and must clear the registers at once.
        @(posedge clk);
        upd();
        #2;
        rst = 0;
        mclear();
        #1;
        chk("async_clear", {8'h00, rdata}, 16'h0000);
        repeat (5) tick();
        rst = 1;
        for (int i = 0; i < 8; i++) rd(i, 8'h00);
        chk("rst_pzero", {15'h0, pzero}, 16'h0000);

        for (int i = 0; i < 8; i++) begin
            wenb = 1; waddr = 3'(i); wdata = 8'(8'h10 + i);
            tick();
        end
        for (int i = 0; i < 8; i++) rd(i, 8'(8'h10 + i));
        rdp(1, 16'h1213);

        pop(2, 1, 0, 0, 16'hBEEF);
        rdp(2, 16'hBEEF);
        rd(4, 8'hBE);
        rd(5, 8'hEF);
        rd(0, 8'h10);
        rd(7, 8'h17);

        pop(1, 1, 0, 0, 16'h00FF);
        pop(1, 0, 1, 0, 16'h0000);
        rdp(1, 16'h0100);
        chk("inc_carry_pz", {15'h0, pzero}, 16'h0000);
        pop(1, 0, 0, 1, 16'h0000);
        rdp(1, 16'h00FF);
        pop(1, 1, 0, 0, 16'hFFFF);
        pop(1, 0, 1, 0, 16'h0000);
        rdp(1, 16'h0000);
        chk("inc_wrap_pz", {15'h0, pzero}, 16'h0001);
        pop(1, 0, 0, 1, 16'h0000);
        rdp(1, 16'hFFFF);
        chk("dec_wrap_pz", {15'h0, pzero}, 16'h0000);
        pop(1, 0, 1, 0, 16'h0000);
        pop(1, 0, 1, 1, 16'h0000);
        rdp(1, 16'h0000);
        chk("incdec_hold_pz", {15'h0, pzero}, 16'h0001);

        pop(3, 1, 1, 0, 16'h1234);
        rdp(3, 16'h1234);
        chk("prio_hold_pz", {15'h0, pzero}, 16'h0001);

        pop(0, 1, 0, 0, 16'h12FF);
        wenb = 1; waddr = 3'd1; wdata = 8'h55;
        pop(0, 0, 1, 0, 16'h0000);
        rd(0, 8'h13);
        rd(1, 8'h55);
        chk("coll_pz", {15'h0, pzero}, 16'h0000);
        pop(0, 1, 0, 0, 16'hFFFF);
        wenb = 1; waddr = 3'd1; wdata = 8'h77;
        pop(0, 0, 1, 0, 16'h0000);
        rdp(0, 16'h0077);
        chk("coll_full_pz", {15'h0, pzero}, 16'h0001);

        repeat (2) tick();
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
